// File: rtl/adder_pkg.sv
// Shared sizing constants for the chunked pipelined adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // One pipeline stage per chunk, so depth and latency are the same number.
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// WIDTH-bit ripple-carry adder chained from full_adder cells.
module adder_chunk #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] q,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .s     (q[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out = carry[WIDTH];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract unit that adds one CHUNK of the operands per stage, with a
// valid/ready handshake on both sides and a whole-pipeline stall.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Stage k holds: its valid bit, the carry out of chunk k, the operand
    // chunks still to be added (shifted down so the next one is always at
    // bit 0), and the finished result chunks (shifted in from the top).
    logic             vld_r   [STAGES];
    logic             carry_r [STAGES];
    logic [WIDTH-1:0] a_r     [STAGES];
    logic [WIDTH-1:0] b_r     [STAGES];
    logic [WIDTH-1:0] q_r     [STAGES];
    logic             ovf_r;

    logic [CHUNK-1:0] op_a    [STAGES];
    logic [CHUNK-1:0] op_b    [STAGES];
    logic             op_c    [STAGES];
    logic [CHUNK-1:0] sum     [STAGES];
    logic             cout    [STAGES];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + 1, so the caller's carry-in is overridden.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign op_a[k] = a[CHUNK-1:0];
            assign op_b[k] = b_eff[CHUNK-1:0];
            assign op_c[k] = cin_eff;
        end else begin : g_next
            assign op_a[k] = a_r[k-1][CHUNK-1:0];
            assign op_b[k] = b_r[k-1][CHUNK-1:0];
            assign op_c[k] = carry_r[k-1];
        end

        adder_chunk #(
            .WIDTH (CHUNK)
        ) u_chunk (
            .a     (op_a[k]),
            .b     (op_b[k]),
            .c_in  (op_c[k]),
            .q     (sum[k]),
            .c_out (cout[k])
        );
    end

    // NOTE: sequential state uses non-blocking (<=) so every stage samples
    // the previous stage's old value on the same edge, giving a true shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage data is reset as well as the valid bits, because
            // q, c_out and ovf are driven straight from it and must read 0.
            for (int k = 0; k < STAGES; k++) begin
                vld_r[k]   <= 1'b0;
                carry_r[k] <= 1'b0;
                a_r[k]     <= '0;
                b_r[k]     <= '0;
                q_r[k]     <= '0;
            end
            ovf_r <= 1'b0;
        end else if (advance) begin
            vld_r[0]   <= in_valid;
            carry_r[0] <= cout[0];
            a_r[0]     <= a >> CHUNK;
            b_r[0]     <= b_eff >> CHUNK;
            q_r[0]     <= WIDTH'(sum[0]) << (WIDTH - CHUNK);
            for (int k = 1; k < STAGES; k++) begin
                vld_r[k]   <= vld_r[k-1];
                carry_r[k] <= cout[k];
                a_r[k]     <= a_r[k-1] >> CHUNK;
                b_r[k]     <= b_r[k-1] >> CHUNK;
                q_r[k]     <= (q_r[k-1] >> CHUNK) | (WIDTH'(sum[k]) << (WIDTH - CHUNK));
            end
            // The last stage sees the operand MSBs, so overflow is decided there.
            ovf_r <= (op_a[LAST][CHUNK-1] == op_b[LAST][CHUNK-1]) &&
                     (sum[LAST][CHUNK-1] != op_a[LAST][CHUNK-1]);
        end
    end

    assign out_valid = vld_r[LAST];
    assign q         = q_r[LAST];
    assign c_out     = carry_r[LAST];
    assign ovf       = ovf_r;

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning the bits added per pipeline stage; WIDTH SHALL be a multiple of CHUNK.
REQ-003 SHALL derive STAGES = WIDTH/CHUNK as a localparam, meaning pipeline depth and latency in cycles.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all flops clock on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the operands on a, b, c_in and sub are valid.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the block accepts operands this cycle.
REQ-008 SHALL have ports a and b, input, WIDTH bits each, the operands.
REQ-009 SHALL have port c_in, input, 1 bit, the carry-in; ignored when sub=1.
REQ-010 SHALL have port sub, input, 1 bit, selecting mode: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1 bit, meaning q, c_out and ovf hold a result.
REQ-012 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result this cycle.
REQ-013 SHALL have port q, output, WIDTH bits, the sum or difference.
REQ-014 SHALL have port c_out, output, 1 bit, the carry out of the MSB; in subtract mode 1 means no borrow.
REQ-015 SHALL have port ovf, output, 1 bit, the two's-complement signed overflow flag.

Function
REQ-016 SHALL compute q = a + b + c_in, mod 2^WIDTH, when sub=0.
REQ-017 SHALL compute q = a + ~b + 1, mod 2^WIDTH, when sub=1.
REQ-018 SHALL assert ovf when the operand MSBs, with b inverted in subtract mode, are equal and q's MSB differs from them.
REQ-019 SHALL add chunk k, bits [k*CHUNK +: CHUNK], in stage k using the carry registered by stage k-1; stage 0 uses the mode-selected carry-in.
REQ-020 SHALL carry the not-yet-added upper operand chunks and the completed lower result chunks forward through stage registers alongside a per-stage valid bit.
REQ-021 SHALL have a latency of exactly STAGES cycles from acceptance (in_valid && in_ready) to out_valid, when no stall occurs.
REQ-022 SHALL advance the whole pipeline when advance = !out_valid || out_ready, and SHALL drive in_ready = advance.
REQ-023 SHALL, when advance=0, hold every stage register and valid bit unchanged, keeping q, c_out and ovf stable while out_valid=1.
REQ-024 SHALL, when in_valid=0 during an advance, insert a bubble (stage-0 valid=0) without blocking data already in flight.
REQ-025 SHALL sustain one accepted operation per cycle while out_ready=1.
REQ-026 SHALL produce results for CHUNK=WIDTH (STAGES=1) with 1-cycle latency.

Reset
REQ-027 SHALL clear all valid bits, q, c_out and ovf to 0 immediately on rst_n low, regardless of clk.
REQ-028 SHALL discard operations in flight when reset asserts mid-operation; no result for them SHALL appear after release.
REQ-029 SHALL drive in_ready=1 during and after reset, since out_valid=0.

Structure
REQ-030 SHALL place default WIDTH/CHUNK constants and the STAGES derivation in shared package adder_pkg.
REQ-031 SHALL instantiate STAGES copies of sub-module adder_chunk (CHUNK-bit ripple adder: a, b, c_in -> q, c_out), built from the existing full_adder cell.

Verification (WIDTH=16, CHUNK=4)
REQ-032 SHALL check add with carry: a=0xFFFF, b=0x0001, c_in=0, sub=0 -> after 4 cycles q=0x0000, c_out=1, ovf=0.
REQ-033 SHALL check signed overflow: a=0x7FFF, b=0x0001, sub=0 -> q=0x8000, c_out=0, ovf=1.
REQ-034 SHALL check subtract with borrow: a=0x0005, b=0x0007, sub=1, c_in=1 -> q=0xFFFE, c_out=0, ovf=0.
REQ-035 SHALL check backpressure: 6 back-to-back ops with out_ready low for 3 cycles at the first result -> in_ready=0 while stalled, q held stable, all 6 results in order with no loss or duplicate.
REQ-036 SHALL check reset mid-flight: rst_n pulsed low 2 cycles after accepting 2 ops -> out_valid=0 immediately, no stale result after release, next op correct after 4 cycles.
REQ-037 SHALL check a random stream of 1000 ops with random in_valid/out_ready against a reference model of REQ-016..018.
